// File: rtl/ifetch_pkg.sv
// Shared types for the instruction prefetch unit: error codes, fetch FSM
// states and the prefetch buffer entry.
package ifetch_pkg;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

  // Entry fields are sized for the widest supported PC/instruction; the top
  // narrows them to ADDR_W/DATA_W on the way out.
  localparam int ENTRY_PC_W    = 64;
  localparam int ENTRY_INSTR_W = 64;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0]    pc;
    logic [ENTRY_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch buffer with flush; pointers and count are reset,
// the storage array is not.
module ifetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output logic                   out_valid,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           storage_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) storage_q[wr_ptr] <= push_data;
  end

  assign head      = storage_q[rd_ptr];
  assign out_valid = (cnt != '0);
  assign count     = cnt;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: program memory, fetch FSM with PC/range checks,
// and a small prefetch buffer feeding a valid/ready consumer.
module instr_prefetch_unit
  import ifetch_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                MEM_DEPTH  = 1024,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_en,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]            ld_data,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [DATA_W-1:0]            out_instr,
  output logic                         err_valid,
  output logic [1:0]                   err_code
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic [DATA_W-1:0] instr_p1;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    pending;
  logic              space_ok;
  logic              issue;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  function automatic logic pc_in_range(input logic [ADDR_W-1:0] pc);
    return (pc >> 2) < ADDR_W'(MEM_DEPTH);
  endfunction

  assign pending  = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(vld_p1);
  assign space_ok = pending < (CNT_W+1)'(FIFO_DEPTH);
  assign issue    = (state != ST_HALT) && !redirect_valid && fetch_en &&
                    space_ok && pc_in_range(fetch_pc_p0);

  // p0 -> p1: fetch FSM and PC; a redirect overrides everything at its edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      fetch_pc_p0 <= RESET_PC;
      vld_p1      <= 1'b0;
      err_valid   <= 1'b0;
      err_code    <= ERR_NONE;
    end else if (redirect_valid) begin
      vld_p1 <= 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        state     <= ST_HALT;
        err_valid <= 1'b1;
        err_code  <= ERR_MISALIGN;
      end else begin
        fetch_pc_p0 <= redirect_pc;
        if (pc_in_range(redirect_pc)) begin
          state     <= ST_RUN;
          err_valid <= 1'b0;
          err_code  <= ERR_NONE;
        end else begin
          state     <= ST_HALT;
          err_valid <= 1'b1;
          err_code  <= ERR_RANGE;
        end
      end
    end else begin
      vld_p1 <= issue;
      case (state)
        ST_HALT: state <= ST_HALT;
        default: begin
          if (fetch_en && space_ok && !pc_in_range(fetch_pc_p0)) begin
            state     <= ST_HALT;
            err_valid <= 1'b1;
            err_code  <= ERR_RANGE;
          end else if (issue) begin
            state       <= ST_RUN;
            fetch_pc_p0 <= fetch_pc_p0 + ADDR_W'(4);
          end else begin
            state <= ST_STALL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (issue) begin
      instr_p1 <= mem[fetch_pc_p0[IDX_W+1:2]];
      pc_p1    <= fetch_pc_p0;
    end
  end

  // p1 -> buffer: returned word is pushed unless the same edge redirects
  assign push = vld_p1 && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = ENTRY_PC_W'(pc_p1);
    push_entry.instr = ENTRY_INSTR_W'(instr_p1);
  end

  ifetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .out_valid (out_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign out_pc    = out_valid ? ADDR_W'(head.pc)    : '0;
  assign out_instr = out_valid ? DATA_W'(head.instr) : '0;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: vector table for the startup stream, hand
// sequences for stall/redirect/error/reset, then a randomized stream.
module tb_instr_prefetch_unit;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int MEM_DEPTH  = 32;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_en;
  logic              ld_en;
  logic [4:0]        ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_instr;
  logic              err_valid;
  logic [1:0]        err_code;

  instr_prefetch_unit #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .MEM_DEPTH  (MEM_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RESET_PC   ('0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .ld_en          (ld_en),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .err_valid      (err_valid),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n_pops = 0;
  logic [31:0] mem_model [MEM_DEPTH];
  logic [31:0] exp_pc;
  logic [31:0] last_pop_pc;

  typedef struct {
    logic        fetch_en;
    logic        out_ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock: the reference stream consumes the pop (or applies the redirect)
  // that the current inputs request, then time moves to just after the edge.
  task automatic cyc();
    if (rst_n && redirect_valid) begin
      if (redirect_pc[1:0] == 2'b00) exp_pc = redirect_pc;
    end else if (rst_n && out_valid && out_ready) begin
      check("pop_pc", out_pc, exp_pc);
      check("pop_instr", out_instr, mem_model[(exp_pc >> 2) % MEM_DEPTH]);
      last_pop_pc = out_pc;
      n_pops++;
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    rst_n = 1'b0; fetch_en = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    exp_pc = '0; last_pop_pc = '0;

    for (int r = 0; r < 9; r++)
      vecs[r] = '{1'b1, 1'b1, (r > 0), (r > 0) ? 32'(4*(r-1)) : 32'd0,
                  (r > 0) ? 32'(32'hA0 + r - 1) : 32'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h1C, 32'hA7};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h1C, 32'hA7};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h20, 32'hA8};

    #3;
    check("rst_valid", out_valid, 0);
    check("rst_pc", out_pc, 0);
    check("rst_instr", out_instr, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_code", err_code, 0);

    for (int i = 0; i < MEM_DEPTH; i++) begin
      ld_en = 1'b1; ld_addr = 5'(i); ld_data = 32'(32'hA0 + i);
      mem_model[i] = 32'(32'hA0 + i);
      @(posedge clk); #1;
    end
    ld_en = 1'b0;

    // startup stream and a short consumer hold, table driven
    rst_n = 1'b1; exp_pc = '0;
    for (int r = 0; r < 12; r++) begin
      fetch_en = vecs[r].fetch_en; out_ready = vecs[r].out_ready;
      cyc();
      check($sformatf("vec%0d_valid", r), out_valid, vecs[r].exp_valid);
      check($sformatf("vec%0d_pc", r), out_pc, vecs[r].exp_pc);
      check($sformatf("vec%0d_instr", r), out_instr, vecs[r].exp_instr);
    end

    // long hold: head stable, then exactly FIFO_DEPTH entries drain
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("hold_valid", out_valid, 1);
      check("hold_pc", out_pc, 32'h20);
      check("hold_instr", out_instr, 32'hA8);
    end
    fetch_en = 1'b0; out_ready = 1'b1; p0 = n_pops;
    for (int i = 0; i < 8; i++) cyc();
    check("drain_count", 32'(n_pops - p0), FIFO_DEPTH);
    check("drain_empty", out_valid, 0);
    fetch_en = 1'b1; p0 = n_pops;
    for (int i = 0; i < 6; i++) cyc();
    check("resume_pops", 32'(n_pops - p0), 4);

    // redirect into a full buffer, same-edge pop ignored
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    check("redir_flush_valid", out_valid, 0);
    cyc();
    check("redir_gap_valid", out_valid, 0);
    cyc();
    check("redir_valid", out_valid, 1);
    check("redir_pc", out_pc, 32'h40);
    check("redir_instr", out_instr, 32'hB0);

    // misaligned redirect halts, aligned redirect recovers
    for (int i = 0; i < 3; i++) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    cyc();
    redirect_valid = 1'b0;
    check("mis_err_valid", err_valid, 1);
    check("mis_err_code", err_code, 2'b01);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("mis_no_push", out_valid, 0);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h08;
    cyc();
    redirect_valid = 1'b0;
    check("recover_err_valid", err_valid, 0);
    check("recover_err_code", err_code, 2'b00);
    cyc(); cyc();
    check("recover_valid", out_valid, 1);
    check("recover_pc", out_pc, 32'h08);
    check("recover_instr", out_instr, 32'hA2);

    // run off the end of memory; last word still pops
    redirect_valid = 1'b1; redirect_pc = 32'h74;
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    check("range_err_valid", err_valid, 1);
    check("range_err_code", err_code, 2'b10);
    check("range_last_pop", last_pop_pc, 32'(4*(MEM_DEPTH-1)));
    check("range_drained", out_valid, 0);

    // asynchronous reset between edges, first while halted then mid-stream
    #2 rst_n = 1'b0;
    #1;
    check("arst_err_valid", err_valid, 0);
    check("arst_err_code", err_code, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; exp_pc = '0;
    for (int i = 0; i < 5; i++) cyc();
    check("stream_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_pc", out_pc, 0);
    check("arst_instr", out_instr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; exp_pc = '0;
    cyc();
    check("restart_e1_valid", out_valid, 0);
    cyc();
    check("restart_valid", out_valid, 1);
    check("restart_pc", out_pc, 32'h0);
    check("restart_instr", out_instr, 32'hA0);

    // randomized enables and periodic redirects against the stream model
    p0 = n_pops;
    for (int c = 0; c < 400; c++) begin
      fetch_en  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      if (c % 12 == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'(4 * $urandom_range(0, 15));
      end else begin
        redirect_valid = 1'b0;
      end
      cyc();
      check("rand_err_valid", err_valid, 0);
    end
    redirect_valid = 1'b0;
    check("rand_progress", 32'(n_pops - p0 > 40), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
